// File: rtl/acl_pkg.sv
// Shared widths and FSM state encoding for the accelerometer display formatter.
package acl_pkg;

  localparam int SAMPLE_W = 12;
  localparam int MAG_W    = 4;
  localparam int DISP_W   = 32;
  localparam int SIGN_BIT = 4;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_READY,
    ST_LOAD
  } acl_state_t;

endpackage

// File: rtl/acl_axis_fmt.sv
// Converts one signed averaged axis value into a sign/magnitude display word.
module acl_axis_fmt
  import acl_pkg::*;
#(
  parameter int SHIFT = 6
) (
  input  logic signed [SAMPLE_W-1:0] avg,
  output logic        [DISP_W-1:0]   disp_word
);

  localparam logic [SAMPLE_W:0] MAG_MAX = {{(SAMPLE_W + 1 - MAG_W){1'b0}}, {MAG_W{1'b1}}};

  logic [SAMPLE_W:0]  avg_ext;
  logic [SAMPLE_W:0]  abs_val;
  logic [SAMPLE_W:0]  shifted;
  logic [MAG_W-1:0]   mag;
  logic               neg;

  // One extra bit so that the most negative sample has a representable magnitude
  always_comb begin
    neg     = avg[SAMPLE_W-1];
    avg_ext = {avg[SAMPLE_W-1], avg};
    abs_val = neg ? (~avg_ext + (SAMPLE_W + 1)'(1)) : avg_ext;
    shifted = abs_val >> SHIFT;
    if (shifted > MAG_MAX) begin
      mag = '1;
    end else begin
      mag = shifted[MAG_W-1:0];
    end
    disp_word              = '0;
    disp_word[MAG_W-1:0]   = mag;
    disp_word[SIGN_BIT]    = neg && (mag != '0);
  end

endmodule

// File: rtl/acl_display_formatter.sv
// Averages accelerometer samples per axis and updates rate-limited display words.
module acl_display_formatter
  import acl_pkg::*;
#(
  parameter int AVG_LOG2    = 3,
  parameter int SHIFT       = 6,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                clk100mhz,
  input  logic                rstn,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] acl_x,
  input  logic [SAMPLE_W-1:0] acl_y,
  input  logic [SAMPLE_W-1:0] acl_z,
  input  logic                freeze,
  output logic [DISP_W-1:0]   displayDataA,
  output logic [DISP_W-1:0]   displayDataB,
  output logic [DISP_W-1:0]   displayDataC,
  output logic                disp_update
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(HOLD_CYCLES - 1);

  acl_state_t                 state;
  acl_state_t                 next_state;
  logic                       load_now;
  logic                       avg_done;
  logic                       avg_pending;
  logic [CNT_W-1:0]           count;
  logic [TMR_W-1:0]           timer;
  logic signed [SAMPLE_W-1:0] samples  [3];
  logic signed [ACC_W-1:0]    acc      [3];
  logic signed [ACC_W-1:0]    acc_sum  [3];
  logic signed [SAMPLE_W-1:0] avg      [3];
  logic [DISP_W-1:0]          fmt_word [3];

  always_comb begin
    samples[0] = acl_x;
    samples[1] = acl_y;
    samples[2] = acl_z;
    for (int i = 0; i < 3; i++) begin
      acc_sum[i] = acc[i] + ACC_W'(samples[i]);
    end
    avg_done = sample_valid && (count == CNT_LAST);
  end

  // The completing sample is folded in directly so the accumulators restart cleanly
  always_ff @(posedge clk100mhz or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      for (int i = 0; i < 3; i++) begin
        acc[i] <= '0;
        avg[i] <= '0;
      end
    end else if (sample_valid) begin
      if (avg_done) begin
        count <= '0;
        for (int i = 0; i < 3; i++) begin
          acc[i] <= '0;
          avg[i] <= SAMPLE_W'(acc_sum[i] >>> AVG_LOG2);
        end
      end else begin
        count <= count + CNT_W'(1);
        for (int i = 0; i < 3; i++) begin
          acc[i] <= acc_sum[i];
        end
      end
    end
  end

  // A freshly completed average wins over the clear from a simultaneous load
  always_ff @(posedge clk100mhz or negedge rstn) begin
    if (!rstn) begin
      avg_pending <= 1'b0;
    end else if (avg_done) begin
      avg_pending <= 1'b1;
    end else if (load_now) begin
      avg_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk100mhz or negedge rstn) begin
    if (!rstn) begin
      timer <= '0;
    end else if (load_now) begin
      timer <= TMR_RELOAD;
    end else if (timer != '0) begin
      timer <= timer - TMR_W'(1);
    end
  end

  always_ff @(posedge clk100mhz or negedge rstn) begin
    if (!rstn) begin
      state <= ST_READY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_now   = 1'b0;
    case (state)
      ST_WAIT: begin
        if (timer == '0) begin
          next_state = ST_READY;
        end
      end
      ST_READY: begin
        if (avg_pending && !freeze) begin
          next_state = ST_LOAD;
          load_now   = 1'b1;
        end
      end
      ST_LOAD: begin
        next_state = ST_WAIT;
      end
      default: begin
        next_state = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk100mhz or negedge rstn) begin
    if (!rstn) begin
      displayDataA <= '0;
      displayDataB <= '0;
      displayDataC <= '0;
      disp_update  <= 1'b0;
    end else begin
      disp_update <= load_now;
      if (load_now) begin
        displayDataA <= fmt_word[0];
        displayDataB <= fmt_word[1];
        displayDataC <= fmt_word[2];
      end
    end
  end

  acl_axis_fmt #(.SHIFT(SHIFT)) u_fmt_x (.avg(avg[0]), .disp_word(fmt_word[0]));
  acl_axis_fmt #(.SHIFT(SHIFT)) u_fmt_y (.avg(avg[1]), .disp_word(fmt_word[1]));
  acl_axis_fmt #(.SHIFT(SHIFT)) u_fmt_z (.avg(avg[2]), .disp_word(fmt_word[2]));

endmodule

// File: tb/tb_acl_display_formatter.sv
// Directed self-checking bench for acl_display_formatter with a short hold window.
module tb_acl_display_formatter;

  logic        clk100mhz = 1'b0;
  logic        rstn = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] acl_x = '0;
  logic [11:0] acl_y = '0;
  logic [11:0] acl_z = '0;
  logic        freeze = 1'b0;
  logic [31:0] displayDataA;
  logic [31:0] displayDataB;
  logic [31:0] displayDataC;
  logic        disp_update;

  int checks = 0;
  int errors = 0;

  acl_display_formatter #(
    .AVG_LOG2(3),
    .SHIFT(6),
    .HOLD_CYCLES(16)
  ) dut (
    .clk100mhz(clk100mhz),
    .rstn(rstn),
    .sample_valid(sample_valid),
    .acl_x(acl_x),
    .acl_y(acl_y),
    .acl_z(acl_z),
    .freeze(freeze),
    .displayDataA(displayDataA),
    .displayDataB(displayDataB),
    .displayDataC(displayDataC),
    .disp_update(disp_update)
  );

  always #5 clk100mhz = ~clk100mhz;

  task automatic send_samples(input int n, input logic [11:0] x, input logic [11:0] y,
                              input logic [11:0] z);
    for (int i = 0; i < n; i++) begin
      @(negedge clk100mhz);
      sample_valid = 1'b1;
      acl_x = x;
      acl_y = y;
      acl_z = z;
    end
    @(negedge clk100mhz);
    sample_valid = 1'b0;
  endtask

  task automatic wait_update(input int limit, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk100mhz);
      cycles++;
      if (disp_update) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk100mhz);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    checks++;
    if (displayDataA !== 32'h0) begin errors++; $display("[TB] FAIL reset_A: got %h expected 00000000", displayDataA); end
    checks++;
    if (displayDataB !== 32'h0) begin errors++; $display("[TB] FAIL reset_B: got %h expected 00000000", displayDataB); end
    checks++;
    if (displayDataC !== 32'h0) begin errors++; $display("[TB] FAIL reset_C: got %h expected 00000000", displayDataC); end
    checks++;
    if (disp_update !== 1'b0) begin errors++; $display("[TB] FAIL reset_upd: got %b expected 0", disp_update); end
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    bit seen;
    int cyc;
    int extra = 0;
    send_samples(8, 12'sd1000, -12'sd300, 12'sd63);
    wait_update(10, seen, cyc);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("[TB] FAIL basic_seen: got %b expected 1", seen); end
    checks++;
    if (cyc != 1) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 1", cyc); end
    checks++;
    if (displayDataA !== 32'h0F) begin errors++; $display("[TB] FAIL basic_A: got %h expected 0000000f", displayDataA); end
    checks++;
    if (displayDataB !== 32'h14) begin errors++; $display("[TB] FAIL basic_B: got %h expected 00000014", displayDataB); end
    checks++;
    if (displayDataC !== 32'h00) begin errors++; $display("[TB] FAIL basic_C: got %h expected 00000000", displayDataC); end
    for (int i = 0; i < 25; i++) begin
      @(negedge clk100mhz);
      if (disp_update) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("[TB] FAIL basic_single_pulse: got %0d extra expected 0", extra); end
  endtask

  task automatic test_saturate();
    bit seen;
    int cyc;
    send_samples(8, 12'h800, -12'sd63, 12'sd2047);
    wait_update(10, seen, cyc);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("[TB] FAIL sat_seen: got %b expected 1", seen); end
    checks++;
    if (displayDataA !== 32'h1F) begin errors++; $display("[TB] FAIL sat_A: got %h expected 0000001f", displayDataA); end
    checks++;
    if (displayDataB !== 32'h00) begin errors++; $display("[TB] FAIL sat_B: got %h expected 00000000", displayDataB); end
    checks++;
    if (displayDataC !== 32'h0F) begin errors++; $display("[TB] FAIL sat_C: got %h expected 0000000f", displayDataC); end
    idle(25);
  endtask

  task automatic test_rounding();
    bit seen;
    int cyc;
    send_samples(4, 12'sd128, 12'sd0, 12'sd0);
    send_samples(4, 12'sd0, 12'sd0, 12'sd0);
    wait_update(10, seen, cyc);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("[TB] FAIL round_pos_seen: got %b expected 1", seen); end
    checks++;
    if (displayDataA !== 32'h01) begin errors++; $display("[TB] FAIL round_pos_A: got %h expected 00000001", displayDataA); end
    idle(25);
    send_samples(7, 12'sd0, 12'sd0, 12'sd0);
    send_samples(1, 12'hFFF, 12'sd0, 12'sd0);
    wait_update(10, seen, cyc);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("[TB] FAIL round_neg_seen: got %b expected 1", seen); end
    checks++;
    if (displayDataA !== 32'h00) begin errors++; $display("[TB] FAIL round_neg_A: got %h expected 00000000", displayDataA); end
    idle(25);
  endtask

  task automatic test_back_to_back();
    int upd = 0;
    int first_at = -1;
    int second_at = -1;
    logic [31:0] first_a = '0;
    logic [31:0] second_a = '0;
    logic [11:0] v_pos = 12'sd128;
    logic [11:0] v_neg = -12'sd1000;
    logic [11:0] v_mid = 12'sd640;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk100mhz);
      if (disp_update) begin
        upd++;
        if (upd == 1) begin
          first_at = i;
          first_a = displayDataA;
        end else if (upd == 2) begin
          second_at = i;
          second_a = displayDataA;
        end
      end
      if (i < 24) begin
        sample_valid = 1'b1;
        acl_x = (i < 8) ? v_pos : ((i < 16) ? v_neg : v_mid);
        acl_y = '0;
        acl_z = '0;
      end else begin
        sample_valid = 1'b0;
      end
    end
    checks++;
    if (upd != 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", upd); end
    checks++;
    if (first_a !== 32'h02) begin errors++; $display("[TB] FAIL b2b_first_A: got %h expected 00000002", first_a); end
    checks++;
    if (second_a !== 32'h0A) begin errors++; $display("[TB] FAIL b2b_latest_A: got %h expected 0000000a", second_a); end
    checks++;
    if (second_at - first_at < 16) begin
      errors++;
      $display("[TB] FAIL b2b_hold_gap: got %0d cycles expected at least 16", second_at - first_at);
    end
    idle(25);
  endtask

  task automatic test_freeze();
    int pulses = 0;
    freeze = 1'b1;
    send_samples(8, -12'sd300, 12'sd0, 12'sd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk100mhz);
      if (disp_update) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("[TB] FAIL freeze_blocked: got %0d pulses expected 0", pulses); end
    checks++;
    if (displayDataA !== 32'h0A) begin errors++; $display("[TB] FAIL freeze_hold_A: got %h expected 0000000a", displayDataA); end
    freeze = 1'b0;
    @(negedge clk100mhz);
    checks++;
    if (disp_update !== 1'b1) begin errors++; $display("[TB] FAIL freeze_release_upd: got %b expected 1", disp_update); end
    checks++;
    if (displayDataA !== 32'h14) begin errors++; $display("[TB] FAIL freeze_release_A: got %h expected 00000014", displayDataA); end
    idle(25);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int cyc;
    send_samples(5, 12'sd1000, 12'sd1000, 12'sd1000);
    rstn = 1'b0;
    @(negedge clk100mhz);
    checks++;
    if (displayDataA !== 32'h0) begin errors++; $display("[TB] FAIL rmid_A: got %h expected 00000000", displayDataA); end
    checks++;
    if (displayDataB !== 32'h0) begin errors++; $display("[TB] FAIL rmid_B: got %h expected 00000000", displayDataB); end
    checks++;
    if (displayDataC !== 32'h0) begin errors++; $display("[TB] FAIL rmid_C: got %h expected 00000000", displayDataC); end
    checks++;
    if (disp_update !== 1'b0) begin errors++; $display("[TB] FAIL rmid_upd: got %b expected 0", disp_update); end
    rstn = 1'b1;
    send_samples(8, 12'sd0, 12'sd0, 12'sd0);
    wait_update(10, seen, cyc);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rmid_seen: got %b expected 1", seen); end
    checks++;
    if (displayDataA !== 32'h0) begin errors++; $display("[TB] FAIL rmid_first_A: got %h expected 00000000", displayDataA); end
    checks++;
    if (displayDataB !== 32'h0) begin errors++; $display("[TB] FAIL rmid_first_B: got %h expected 00000000", displayDataB); end
    checks++;
    if (displayDataC !== 32'h0) begin errors++; $display("[TB] FAIL rmid_first_C: got %h expected 00000000", displayDataC); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_rounding();
    test_back_to_back();
    test_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
